// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Single-entry builds name their occupied state FULL.
  localparam occ_e FULL = ONE;

  localparam int unsigned PIPE_WIDTH_DEF = 32;
  localparam int unsigned PIPE_CNT_W_DEF = 16;

  localparam int unsigned IFID_W = 32;
  localparam int unsigned IDEX_W = 86;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready payload handshake between pipeline stages
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = pipe_pkg::PIPE_WIDTH_DEF
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stall_ctr.sv
// rtl/pipe_stall_ctr.sv - saturating stall-cycle counter with synchronous clear
module pipe_stall_ctr #(
  parameter int unsigned CNT_W = pipe_pkg::PIPE_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with flush and stall counter
// PIPE_SKID_EN adds a skid entry so in_ready is registered (capacity 2).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = PIPE_WIDTH_DEF,
  parameter int unsigned      CNT_W    = PIPE_CNT_W_DEF,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   in_if,
  pipe_stage_reg_if.master  out_if,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_if.valid && in_if.ready;
  assign out_xfer = out_if.valid && out_if.ready;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = ONE;
          main_d  = in_if.data;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_if.data;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_if.data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        // in_ready is low here, so only a drain can happen.
        TWO: if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_if.valid = (state_q != EMPTY);
    out_if.data  = main_q;
    in_if.ready  = (state_q != TWO);
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_DATA;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_d = FULL;
          main_d  = in_if.data;
        end
        // An input transfer while FULL implies the held entry drains too.
        FULL: begin
          if (in_xfer) begin
            main_d = in_if.data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_if.valid = (state_q != EMPTY);
    out_if.data  = main_q;
    in_if.ready  = (state_q == EMPTY) || out_if.ready;
  end
`endif

  pipe_stall_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (stat_clr),
    .inc_i  ((state_q != EMPTY) && !out_if.ready),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the processor datapath, replacing the fixed-width, enable-only stage registers between IF/ID/EX/MEM/WB. It carries a WIDTH-bit payload with a valid/ready handshake, and supports flush (bubble injection) for branch and exception recovery. It keeps a saturating stall-cycle counter for performance debug. An optional skid entry fully registers the upstream ready path.

## Interface
- WIDTH, 32: payload width in bits, ≥1.
- CNT_W, 16: stall-counter width in bits, ≥1.
- RST_DATA, 0: value loaded into payload registers on reset and on flush.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Synchronous, active-low: sampled on the rising edge of clk while 0.
- in_valid  in  1  upstream holds a valid payload.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage accepts a payload this cycle.
- out_valid  out  1  stage presents a valid payload.
- out_data  out  WIDTH  presented payload.
- out_ready  in  1  downstream accepts this cycle.
- flush  in  1  discard all held entries at the next edge.
- stat_clr  in  1  clear the stall counter.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

## Operation
- **Transfers.**
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- **Order.** Payloads leave in arrival order; none is duplicated or dropped, except on flush.
- **Occupancy states.**
  - Without skid: EMPTY and FULL.
  - With skid: EMPTY, ONE and TWO.
- **Transitions, without skid.**
  - EMPTY→FULL on an input transfer.
  - FULL→EMPTY on an output transfer with no input transfer.
  - FULL stays FULL on a simultaneous input and output transfer; the main register reloads.
- **Transitions, with skid.**
  - EMPTY→ONE on an input transfer.
  - ONE→TWO on an input transfer without an output transfer; the payload goes to the skid register.
  - ONE→EMPTY on an output transfer without an input transfer.
  - TWO→ONE on an output transfer; the skid register moves to main.
- **Flush.**
  - At the next edge: state→EMPTY, out_valid→0, payload registers→RST_DATA.
  - Flush has priority over any same-cycle input transfer; that payload is discarded.
  - in_ready keeps its normal value during flush.
- **Stall counter.**
  - Increments by 1 each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W−1.
  - stat_clr loads 0 and takes priority over increment.
  - flush does not affect the counter.
- **Reset values.** out_valid=0, out_data=RST_DATA, stall_cnt=0, state EMPTY. in_ready=1 in the first cycle after reset.

## Timing
- **Latency.** 1 cycle: a payload accepted at edge N is on out_data after edge N, provided the stage was empty or drains in the same cycle.
- **Throughput.** 1 payload per cycle when out_ready is held at 1.
- **Outputs.** out_valid and out_data are always registered, never combinational from inputs.
- **in_ready without skid.** Combinational: in_ready = !out_valid || out_ready.
- **in_ready with skid.** Registered: in_ready = (state != TWO).
- **Reset mid-operation.** rst low at any edge discards all entries, exactly like flush, and also clears stall_cnt.

## Configuration
- **PIPE_SKID_EN defined:**
  - Adds the skid register and the ONE/TWO states.
  - in_ready has no combinational path from out_ready.
  - Capacity is 2.
- **PIPE_SKID_EN undefined:**
  - Single register, capacity 1.
  - in_ready depends combinationally on out_ready.
- All other behaviour is identical in both builds.

## Structure
- **Shared package `pipe_pkg`:**
  - Occupancy-state typedef: EMPTY, ONE/FULL, TWO.
  - Default WIDTH and CNT_W constants.
  - Stage-bundle payload widths for IFID (32) and IDEX (86).
- **One sub-module, `pipe_stall_ctr`:** saturating counter with clear, CNT_W-parameterised, instantiated once.
- The payload registers are plain vector registers with WIDTH-generic code; no per-bit instantiation.

## Test plan
- **Reset.**
  - Stimulus: rst=0 for 2 cycles, then 1.
  - Required: out_valid=0, out_data=RST_DATA, stall_cnt=0, in_ready=1.
- **Streaming.**
  - Stimulus: out_ready=1; in_valid=1 with data 0x1, 0x2, 0x3, 0x4 on consecutive cycles.
  - Required: out_data shows 0x1..0x4 one cycle later, with no gaps.
- **Backpressure.**
  - Stimulus: push 0xA; out_ready=0 for 5 cycles; push 0xB.
  - Required, skid build:
    - 0xB is accepted and in_ready=0 the following cycle.
    - After out_ready=1, the output is 0xA then 0xB.
    - stall_cnt=5.
  - Required, no-skid build: 0xB is held off (in_ready=0) until 0xA drains.
- **Flush with input.**
  - Stimulus: stage holding 0xA (TWO state with 0xB in the skid build); assert flush together with in_valid=1, data 0xC.
  - Required: next cycle out_valid=0, and 0xC never appears.
- **Counter saturation.**
  - Stimulus: CNT_W=3; hold out_valid=1, out_ready=0 for 10 cycles.
  - Required: stall_cnt=7.
  - Then: stat_clr together with the stall gives stall_cnt=0.
- **Simultaneous in/out when full.**
  - Stimulus: holding 0x5, out_ready=1, in_valid=1 with 0x6 in the same cycle.
  - Required: 0x5 transfers and out_data=0x6 next cycle; occupancy is unchanged.
